// File: rtl/fb_line_fetch_if.sv
// rtl/fb_line_fetch_if.sv - Avalon-MM pipelined read bus between line fetcher and framebuffer memory
interface fb_line_fetch_if;
  logic        mem_read;
  logic [23:0] mem_address;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_waitrequest,
    input  mem_readdata,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_waitrequest,
    output mem_readdata,
    output mem_readdatavalid
  );
endinterface

// File: rtl/fb_line_fetch.sv
// rtl/fb_line_fetch.sv - RGB332 framebuffer line fetcher with ping-pong line buffer feeding vpg
module fb_line_fetch #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [23:0] FB_BASE  = 24'h000000,
  parameter int          MAX_PEND = 8,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             pixel_x,
  input  logic [8:0]             pixel_y,
  input  logic                   de,
  input  logic                   vs,
  fb_line_fetch_if.master        mem,
  output logic [23:0]            color,
  output logic                   underrun
);

  localparam int WPL = H_ACTIVE / 4;
  localparam int WW  = $clog2(WPL + 1);
  localparam int AW  = $clog2(WPL);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t        state;
  logic          de_q;
  logic          vs_q;
  logic [8:0]    y_q;
  logic [8:0]    line;
  logic [WW-1:0] issued;
  logic [WW-1:0] wr;
  logic [3:0]    pend;

  logic [31:0]   line_buf [2][WPL];

  logic          vs_rise;
  logic          de_fall;
  logic          trig;
  logic [8:0]    trig_line;
  logic          accept;
  logic          rvalid_ok;
  logic [4:0]    pend_next;
  logic [WW-1:0] issued_next;
  logic [23:0]   next_addr;
  logic [23:0]   trig_addr;
  logic          x_in_range;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic [7:0]    pix;

  // Trigger detection and request/response bookkeeping for the next edge
  always_comb begin
    vs_rise     = vs & ~vs_q;
    de_fall     = de_q & ~de;
    trig_line   = vs_rise ? 9'd0 : (y_q + 9'd1);
    trig        = vs_rise | (de_fall && ((int'(y_q) + 1) < V_ACTIVE));
    accept      = mem.mem_read & ~mem.mem_waitrequest;
    rvalid_ok   = mem.mem_readdatavalid && (pend != 4'd0);
    pend_next   = {1'b0, pend} + {4'b0, accept} - {4'b0, rvalid_ok};
    issued_next = issued + WW'(accept);
    next_addr   = FB_BASE + 24'(line) * 24'(WPL) + 24'(issued_next);
    trig_addr   = FB_BASE + 24'(trig_line) * 24'(WPL);
  end

  // Video strobe history used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      y_q  <= 9'd0;
    end else begin
      de_q <= de;
      vs_q <= vs;
      y_q  <= pixel_y;
    end
  end

  // Fetch FSM: issue one line of reads, throttle on outstanding count, wait for all data
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      mem.mem_read    <= 1'b0;
      mem.mem_address <= 24'd0;
      underrun        <= 1'b0;
      pend            <= 4'd0;
      issued          <= '0;
      wr              <= '0;
      line            <= 9'd0;
    end else begin
      pend <= pend_next[3:0];
      if (rvalid_ok) wr <= wr + 1'b1;
      if (trig && state != IDLE) underrun <= 1'b1;
      case (state)
        IDLE: begin
          if (trig) begin
            state           <= REQ;
            line            <= trig_line;
            issued          <= '0;
            wr              <= '0;
            mem.mem_read    <= 1'b1;
            mem.mem_address <= trig_addr;
          end
        end
        REQ: begin
          if (accept) issued <= issued_next;
          if (accept && issued == WW'(WPL - 1)) begin
            state        <= DRAIN;
            mem.mem_read <= 1'b0;
          end else begin
            mem.mem_read    <= (int'(pend_next) < MAX_PEND);
            mem.mem_address <= next_addr;
          end
        end
        DRAIN: begin
          if (wr == WW'(WPL)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Returned words land in the bank chosen by the line's parity, in arrival order
  always_ff @(posedge clk) begin
    if (!reset && rvalid_ok && (int'(wr) < WPL)) line_buf[line[0]][AW'(wr)] <= mem.mem_readdata;
  end

  // Pixel lookup from the bank matching the displayed line's parity
  always_comb begin
    x_in_range = (int'(pixel_x) < H_ACTIVE);
    rd_idx     = x_in_range ? AW'(pixel_x >> 2) : '0;
    rd_word    = line_buf[pixel_y[0]][rd_idx];
    pix        = 8'(rd_word >> {pixel_x[1:0], 3'b000});
  end

  // Registered RGB332 to RGB888 expansion, background outside active video
  always_ff @(posedge clk) begin
    if (reset) begin
      color <= BG_COLOR;
    end else if (!de || !x_in_range) begin
      color <= BG_COLOR;
    end else begin
      color <= {pix[7:5], pix[7:5], pix[7:6],
                pix[4:2], pix[4:2], pix[4:3],
                {4{pix[1:0]}}};
    end
  end

endmodule

// File: tb/tb_fb_line_fetch.sv
// tb/tb_fb_line_fetch.sv - randomized self-checking bench for fb_line_fetch against a framebuffer model
module tb_fb_line_fetch;

  localparam int          H_ACTIVE = 640;
  localparam int          V_ACTIVE = 480;
  localparam int          WPL      = H_ACTIVE / 4;
  localparam logic [23:0] FB_BASE  = 24'h000000;
  localparam logic [23:0] BG       = 24'h000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        de;
  logic        vs;
  logic [23:0] color;
  logic        underrun;

  fb_line_fetch_if memif ();

  fb_line_fetch #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .FB_BASE  (FB_BASE),
    .MAX_PEND (8),
    .BG_COLOR (BG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pixel_x  (pixel_x),
    .pixel_y  (pixel_y),
    .de       (de),
    .vs       (vs),
    .mem      (memif.master),
    .color    (color),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fb_seed;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_ret = 0;
  int          max_out = 0;
  int          lat = 1;
  int          stall_at = -1;
  int          stall_len = 5;
  bit          stall_chk_en = 1'b1;
  logic [23:0] acc_addr[$];
  int          acc_cyc[$];
  logic [23:0] q_addr[$];
  int          q_due[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fb_word(input logic [23:0] a);
    if (a == FB_BASE) return 32'hE01C03FF;
    return (32'(a) * 32'h9E3779B9) ^ fb_seed;
  endfunction

  function automatic logic [23:0] exp_color(input int y, input int x);
    logic [31:0] w;
    logic [7:0]  p;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    w = fb_word(FB_BASE + 24'(y * WPL + x / 4));
    p = 8'(w >> (8 * (x % 4)));
    r = p[7:5];
    g = p[4:2];
    b = p[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Avalon-MM slave: fixed latency, in-order returns, optional waitrequest burst
  initial begin : mem_model
    logic        in_stall;
    logic [23:0] stall_addr;
    int          stall_left;
    int          last_stall_at;
    in_stall      = 1'b0;
    stall_addr    = '0;
    stall_left    = 0;
    last_stall_at = -1;
    memif.mem_waitrequest   = 1'b0;
    memif.mem_readdata      = '0;
    memif.mem_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      if (memif.mem_read && !memif.mem_waitrequest) begin
        acc_addr.push_back(memif.mem_address);
        acc_cyc.push_back(cyc);
        q_addr.push_back(memif.mem_address);
        q_due.push_back(cyc + lat);
        n_acc++;
      end
      if (n_acc - n_ret > max_out) max_out = n_acc - n_ret;
      if (memif.mem_waitrequest && stall_chk_en) begin
        if (in_stall) begin
          check("stall_read", memif.mem_read, 1);
          check("stall_addr", memif.mem_address, stall_addr);
        end else if (memif.mem_read) begin
          in_stall   = 1'b1;
          stall_addr = memif.mem_address;
        end
      end else begin
        in_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        memif.mem_readdata      = fb_word(q_addr.pop_front());
        void'(q_due.pop_front());
        memif.mem_readdatavalid = 1'b1;
        n_ret++;
      end else begin
        memif.mem_readdatavalid = 1'b0;
        memif.mem_readdata      = $urandom;
      end
      if (stall_left > 0) begin
        memif.mem_waitrequest = 1'b1;
        stall_left--;
      end else if (n_acc == stall_at && last_stall_at != stall_at) begin
        last_stall_at         = stall_at;
        stall_left            = stall_len - 1;
        memif.mem_waitrequest = 1'b1;
      end else begin
        memif.mem_waitrequest = 1'b0;
      end
    end
  end

  task automatic pulse_vs();
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
  endtask

  task automatic wait_fetch(input int base, input string tag);
    int t;
    t = 0;
    while (!(n_acc >= base + WPL && q_addr.size() == 0) && t < 6000) begin
      tick();
      t++;
    end
    check({tag, "_done"}, (t < 6000), 1);
    repeat (4) tick();
  endtask

  task automatic check_addrs(input int base, input int line);
    check($sformatf("n_acc_l%0d", line), n_acc, base + WPL);
    for (int i = 0; i < WPL; i++) begin
      if (acc_addr.size() > base + i)
        check($sformatf("addr_l%0d_w%0d", line, i), acc_addr[base + i], FB_BASE + 24'(line * WPL + i));
    end
  endtask

  task automatic read_line(input int y, input bit trig_next);
    pixel_y = 9'(y);
    for (int x = 0; x < H_ACTIVE + 2; x++) begin
      pixel_x = 10'(x);
      de      = 1'b1;
      tick();
      check($sformatf("pix_y%0d_x%0d", y, x), color, (x < H_ACTIVE) ? exp_color(y, x) : BG);
    end
    if (!trig_next) begin
      pixel_y = 9'(V_ACTIVE - 1);
      tick();
    end
    de = 1'b0;
    tick();
    check("bg_de0", color, BG);
  endtask

  initial begin : main
    int          b;
    int          t;
    logic [23:0] w0_exp [4];
    w0_exp[0] = 24'hFFFFFF;
    w0_exp[1] = 24'h0000FF;
    w0_exp[2] = 24'h00FF00;
    w0_exp[3] = 24'hFF0000;
    fb_seed = $urandom;
    reset   = 1'b1;
    pixel_x = '0;
    pixel_y = '0;
    de      = 1'b0;
    vs      = 1'b0;
    repeat (3) tick();
    check("rst_color", color, BG);
    check("rst_read", memif.mem_read, 0);
    check("rst_addr", memif.mem_address, 0);
    check("rst_underrun", underrun, 0);
    reset = 1'b0;
    tick();

    pixel_y = 9'(V_ACTIVE - 1);
    pixel_x = 10'd5;
    de      = 1'b1;
    tick();
    check("no_x_color", $isunknown(color), 0);
    pixel_x = 10'd700;
    tick();
    check("bg_x_over", color, BG);
    de = 1'b0;
    repeat (20) tick();
    check("no_fetch_last_line", n_acc, 0);
    check("idle_read", memif.mem_read, 0);

    lat = $urandom_range(1, 3);
    b   = n_acc;
    pulse_vs();
    wait_fetch(b, "l0");
    check_addrs(b, 0);
    if (acc_cyc.size() >= b + WPL) check("consec_l0", acc_cyc[b + WPL - 1] - acc_cyc[b], WPL - 1);
    pixel_y = 9'd0;
    for (int i = 0; i < 4; i++) begin
      pixel_x = 10'(i);
      de      = 1'b1;
      tick();
      check($sformatf("word0_px%0d", i), color, w0_exp[i]);
    end

    stall_len = 5;
    stall_at  = n_acc + $urandom_range(20, 120);
    b         = n_acc;
    read_line(0, 1'b1);
    wait_fetch(b, "l1");
    check_addrs(b, 1);

    lat = 20;
    b   = n_acc;
    read_line(1, 1'b1);
    wait_fetch(b, "l2");
    check_addrs(b, 2);
    check("pend_peak", max_out, 8);

    b = n_acc;
    read_line(2, 1'b1);
    check("underrun_clear", underrun, 0);
    repeat (10) tick();
    pixel_y = 9'd9;
    de      = 1'b1;
    repeat (3) tick();
    de = 1'b0;
    repeat (2) tick();
    check("underrun_set", underrun, 1);
    wait_fetch(b, "l3");
    check_addrs(b, 3);
    repeat (40) tick();
    check("dropped_l10", n_acc, b + WPL);
    read_line(3, 1'b0);
    check("underrun_sticky", underrun, 1);

    lat          = 30;
    stall_chk_en = 1'b0;
    b            = n_acc;
    stall_len    = 12;
    stall_at     = b + 4;
    pulse_vs();
    t = 0;
    while (n_acc < b + 4 && t < 200) begin
      tick();
      t++;
    end
    check("rst_pend4_reached", (t < 200), 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_read", memif.mem_read, 0);
    check("midrst_underrun", underrun, 0);
    check("midrst_color", color, BG);
    t = 0;
    while (q_addr.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("strays_sent", (t < 200), 1);
    repeat (3) tick();
    check("strays_read", memif.mem_read, 0);
    check("strays_no_req", n_acc, b + 4);
    pixel_y = 9'd2;
    for (int x = 0; x < 16; x++) begin
      pixel_x = 10'(x);
      de      = 1'b1;
      tick();
      check($sformatf("kept_y2_x%0d", x), color, exp_color(2, x));
    end
    pixel_y = 9'(V_ACTIVE - 1);
    tick();
    de = 1'b0;
    tick();

    lat          = 1;
    stall_chk_en = 1'b1;
    b            = n_acc;
    pulse_vs();
    wait_fetch(b, "l0b");
    check_addrs(b, 0);
    if (acc_cyc.size() >= b + WPL) check("consec_l0b", acc_cyc[b + WPL - 1] - acc_cyc[b], WPL - 1);
    read_line(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
